// File: rtl/r_channel.sv
// Read-data return path of the AXI upsizer: packs 1, 2 or 4 narrow slave beats into one
// wide master beat and merges the slave sub-bursts of a split read into one master burst.
module r_channel #(
  parameter int M_DATA_WIDTH    = 128,
  parameter int S_DATA_WIDTH    = 32,
  parameter int RID_WIDTH       = 3,
  parameter int RESP_WIDTH      = 2,
  parameter int XFER_D_IN       = 6,
  parameter int XFER_FIFO_DEPTH = 8
) (
  input  logic                    aclk,
  input  logic                    arst_n,
  input  logic [XFER_D_IN-1:0]    xfer_data_i,
  input  logic                    xfer_wr_valid_i,
  output logic                    xfer_full_o,
  input  logic [RID_WIDTH-1:0]    s_rid,
  input  logic [S_DATA_WIDTH-1:0] s_rdata,
  input  logic [RESP_WIDTH-1:0]   s_rresp,
  input  logic                    s_rlast,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  output logic [RID_WIDTH-1:0]    m_rid,
  output logic [M_DATA_WIDTH-1:0] m_rdata,
  output logic [RESP_WIDTH-1:0]   m_rresp,
  output logic                    m_rlast,
  output logic                    m_rvalid,
  input  logic                    m_rready
);

  localparam int LANES  = M_DATA_WIDTH / S_DATA_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = $clog2(XFER_FIFO_DEPTH);
  localparam logic [LANE_W-1:0] LANE_ONE = LANE_W'(1);
  localparam logic [PTR_W:0]    PTR_ONE  = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COLLECT = 2'd2,
    SEND    = 2'd3
  } state_t;

  function automatic logic [2:0] sanitize_n(input logic [2:0] cnt);
    logic [2:0] res;
    case (cnt)
      3'd1, 3'd2, 3'd4: res = cnt;
      default:          res = 3'd1;
    endcase
    return res;
  endfunction

  function automatic logic [2:0] sanitize_t(input logic [2:0] cnt);
    logic [2:0] res;
    if (cnt == 3'd0) res = 3'd1;
    else             res = cnt;
    return res;
  endfunction

  function automatic logic [RESP_WIDTH-1:0] resp_max(input logic [RESP_WIDTH-1:0] a,
                                                     input logic [RESP_WIDTH-1:0] b);
    logic [RESP_WIDTH-1:0] res;
    if (a > b) res = a;
    else       res = b;
    return res;
  endfunction

  state_t                  state_r, state_s;
  logic [XFER_D_IN-1:0]    fifo_mem_r [XFER_FIFO_DEPTH];
  logic [PTR_W:0]          wr_ptr_r, rd_ptr_r;
  logic                    fifo_full_s, fifo_empty_s, push_s, pop_s;
  logic [XFER_D_IN-1:0]    fifo_head_s;
  logic [2:0]              n_r, t_r, txn_r;
  logic [LANE_W-1:0]       lane_r;
  logic [RID_WIDTH-1:0]    rid_r;
  logic [M_DATA_WIDTH-1:0] rdata_r;
  logic [RESP_WIDTH-1:0]   rresp_r;
  logic                    rlast_r;
  logic                    s_hs_s, m_hs_s, close_s;

  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                        (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  // A push while full is still taken when LOAD frees a slot on the same edge.
  assign pop_s        = (state_r == LOAD);
  assign push_s       = xfer_wr_valid_i && (!fifo_full_s || pop_s);
  assign fifo_head_s  = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];

  assign s_hs_s  = s_rvalid && (state_r == COLLECT);
  assign m_hs_s  = m_rready && (state_r == SEND);
  assign close_s = s_hs_s && (s_rlast || (3'(lane_r) == (n_r - 3'd1)));

  assign xfer_full_o = fifo_full_s;
  assign s_rready    = (state_r == COLLECT);
  assign m_rvalid    = (state_r == SEND);
  assign m_rid       = rid_r;
  assign m_rdata     = rdata_r;
  assign m_rresp     = rresp_r;
  assign m_rlast     = rlast_r;

  // Descriptor storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge aclk) begin
    if (push_s) fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= xfer_data_i;
  end

  // Descriptor FIFO pointers.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // State register.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) state_r <= IDLE;
    else         state_r <= state_s;
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (!fifo_empty_s) state_s = LOAD;    else state_s = IDLE;
      LOAD:    state_s = COLLECT;
      COLLECT: if (close_s)       state_s = SEND;    else state_s = COLLECT;
      SEND: begin
        if (m_hs_s) begin
          if (rlast_r) state_s = IDLE;
          else         state_s = COLLECT;
        end else begin
          state_s = SEND;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Group datapath: descriptor latch, lane packing, response merge and sub-burst count.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      n_r     <= 3'd1;
      t_r     <= 3'd1;
      txn_r   <= 3'd0;
      lane_r  <= '0;
      rid_r   <= '0;
      rdata_r <= '0;
      rresp_r <= '0;
      rlast_r <= 1'b0;
    end else if (pop_s) begin
      n_r     <= sanitize_n(fifo_head_s[5:3]);
      t_r     <= sanitize_t(fifo_head_s[2:0]);
      txn_r   <= 3'd0;
      lane_r  <= '0;
      rdata_r <= '0;
      rresp_r <= '0;
      rlast_r <= 1'b0;
    end else if (s_hs_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_r == LANE_W'(i)) rdata_r[i*S_DATA_WIDTH +: S_DATA_WIDTH] <= s_rdata;
      end
      rresp_r <= resp_max(rresp_r, s_rresp);
      if (lane_r == '0) rid_r <= s_rid;
      lane_r <= lane_r + LANE_ONE;
      if (s_rlast && (txn_r < (t_r - 3'd1))) txn_r <= txn_r + 3'd1;
      if (close_s) rlast_r <= s_rlast && (txn_r == (t_r - 3'd1));
    end else if (m_hs_s && !rlast_r) begin
      lane_r  <= '0;
      rdata_r <= '0;
      rresp_r <= '0;
    end
  end

endmodule

// File: tb/tb_r_channel.sv
// Self-checking bench for r_channel: directed scenarios plus randomized traffic checked
// against a chunking reference model of the upsizer read path.
module tb_r_channel;

  logic         aclk = 1'b0;
  logic         arst_n;
  logic [5:0]   xfer_data_i;
  logic         xfer_wr_valid_i;
  logic         xfer_full_o;
  logic [2:0]   s_rid;
  logic [31:0]  s_rdata;
  logic [1:0]   s_rresp;
  logic         s_rlast, s_rvalid, s_rready;
  logic [2:0]   m_rid;
  logic [127:0] m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rlast, m_rvalid, m_rready;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0]  rid;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } sbeat_t;

  typedef struct packed {
    logic [2:0]   rid;
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
  } mbeat_t;

  sbeat_t tq[$];
  sbeat_t sq[$];
  mbeat_t exp_q[$];
  mbeat_t got_q[$];

  r_channel dut (
    .aclk(aclk), .arst_n(arst_n),
    .xfer_data_i(xfer_data_i), .xfer_wr_valid_i(xfer_wr_valid_i), .xfer_full_o(xfer_full_o),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 aclk = ~aclk;

  task automatic do_reset();
    @(negedge aclk);
    arst_n = 1'b0;
    xfer_wr_valid_i = 1'b0; xfer_data_i = 6'd0;
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rid = 3'd0; s_rdata = 32'd0; s_rresp = 2'd0;
    m_rready = 1'b0;
    tq.delete(); sq.delete(); exp_q.delete(); got_q.delete();
    repeat (2) @(negedge aclk);
    arst_n = 1'b1;
    @(negedge aclk);
  endtask

  // Returns at the falling edge right after the pushing rising edge.
  task automatic push_desc(input logic [2:0] n_raw, input logic [2:0] t_raw);
    @(negedge aclk);
    xfer_data_i = {n_raw, t_raw};
    xfer_wr_valid_i = 1'b1;
    @(negedge aclk);
    xfer_wr_valid_i = 1'b0;
  endtask

  task automatic add_sub(input int len, input logic [2:0] rid);
    sbeat_t b;
    for (int i = 0; i < len; i++) begin
      b.rid = rid; b.data = $urandom; b.resp = 2'($urandom_range(0, 3));
      b.last = (i == len - 1);
      tq.push_back(b);
    end
  endtask

  // Reference: split the beats of one descriptor into sub-bursts at each rlast, cut
  // every sub-burst into chunks of n beats, and flag the final chunk of sub-burst t.
  task automatic model_txn(input logic [2:0] n_raw, input logic [2:0] t_raw);
    int n, t, sub, start, len;
    mbeat_t mb;
    n = (n_raw == 3'd1 || n_raw == 3'd2 || n_raw == 3'd4) ? int'(n_raw) : 1;
    t = (t_raw == 3'd0) ? 1 : int'(t_raw);
    sub = 0; start = 0;
    for (int i = 0; i < tq.size(); i++) begin
      if (tq[i].last) begin
        len = i - start + 1;
        for (int g = 0; g < len; g += n) begin
          mb = '0;
          mb.rid = tq[start + g].rid;
          for (int k = 0; k < n && g + k < len; k++) begin
            mb.data[32*k +: 32] = tq[start + g + k].data;
            if (tq[start + g + k].resp > mb.resp) mb.resp = tq[start + g + k].resp;
          end
          mb.last = (g + n >= len) && (sub >= t - 1);
          exp_q.push_back(mb);
        end
        sub++;
        start = i + 1;
      end
      sq.push_back(tq[i]);
    end
    tq.delete();
  endtask

  // Drives queued slave beats and records master handshakes; ends on a falling edge.
  task automatic run(input int max_cycles, input int vpct, input int rpct, input bit slave_only);
    int cyc = 0;
    mbeat_t mb;
    while ((slave_only ? (sq.size() > 0) : (sq.size() > 0 || got_q.size() < exp_q.size()))
           && cyc < max_cycles) begin
      @(negedge aclk);
      cyc++;
      if (sq.size() > 0 && $urandom_range(0, 99) < vpct) begin
        s_rvalid = 1'b1; s_rid = sq[0].rid; s_rdata = sq[0].data;
        s_rresp = sq[0].resp; s_rlast = sq[0].last;
      end else begin
        s_rvalid = 1'b0; s_rid = 3'($urandom_range(0, 7)); s_rdata = $urandom;
        s_rresp = 2'($urandom_range(0, 3)); s_rlast = 1'($urandom_range(0, 1));
      end
      m_rready = ($urandom_range(0, 99) < rpct);
      if (s_rvalid && s_rready) void'(sq.pop_front());
      if (m_rvalid && m_rready) begin
        mb.rid = m_rid; mb.data = m_rdata; mb.resp = m_rresp; mb.last = m_rlast;
        got_q.push_back(mb);
      end
    end
    @(negedge aclk);
    s_rvalid = 1'b0;
    m_rready = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    xfer_wr_valid_i = 1'b0; xfer_data_i = 6'd0;
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rid = 3'd0; s_rdata = 32'd0; s_rresp = 2'd0;
    m_rready = 1'b0;
    repeat (3) @(negedge aclk);
    checks++; if (s_rready !== 1'b0) begin failures++; $display("FAIL reset_s_rready got=%b exp=0", s_rready); end
    checks++; if (m_rvalid !== 1'b0) begin failures++; $display("FAIL reset_m_rvalid got=%b exp=0", m_rvalid); end
    checks++; if (m_rlast !== 1'b0) begin failures++; $display("FAIL reset_m_rlast got=%b exp=0", m_rlast); end
    checks++; if (m_rdata !== 128'd0) begin failures++; $display("FAIL reset_m_rdata got=%h exp=0", m_rdata); end
    checks++; if (m_rresp !== 2'd0) begin failures++; $display("FAIL reset_m_rresp got=%0d exp=0", m_rresp); end
    checks++; if (m_rid !== 3'd0) begin failures++; $display("FAIL reset_m_rid got=%0d exp=0", m_rid); end
    checks++; if (xfer_full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", xfer_full_o); end
    arst_n = 1'b1;
    repeat (3) @(negedge aclk);
    checks++; if (s_rready !== 1'b0) begin failures++; $display("FAIL idle_s_rready got=%b exp=0", s_rready); end
  endtask

  task automatic test_pack4();
    sbeat_t b;
    do_reset();
    push_desc(3'd4, 3'd1);
    checks++; if (s_rready !== 1'b0) begin failures++; $display("FAIL push_lat_e0 got=%b exp=0", s_rready); end
    @(negedge aclk);
    checks++; if (s_rready !== 1'b0) begin failures++; $display("FAIL push_lat_e1 got=%b exp=0", s_rready); end
    @(negedge aclk);
    checks++; if (s_rready !== 1'b1) begin failures++; $display("FAIL push_lat_e2 got=%b exp=1", s_rready); end
    for (int i = 0; i < 8; i++) begin
      b.rid = 3'd6; b.data = 32'(i); b.resp = 2'd0; b.last = (i == 7);
      tq.push_back(b);
    end
    model_txn(3'd4, 3'd1);
    run(200, 100, 100, 1'b0);
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL pack4_count got=%0d exp=2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0].data !== 128'h00000003_00000002_00000001_00000000 || got_q[0].last !== 1'b0) begin
        failures++; $display("FAIL pack4_beat1 got=%h last=%b exp=00000003000000020000000100000000 last=0", got_q[0].data, got_q[0].last);
      end
      checks++; if (got_q[1].data !== 128'h00000007_00000006_00000005_00000004 || got_q[1].last !== 1'b1) begin
        failures++; $display("FAIL pack4_beat2 got=%h last=%b exp=00000007000000060000000500000004 last=1", got_q[1].data, got_q[1].last);
      end
    end
  endtask

  task automatic test_n1_t3();
    int upper_nz = 0;
    int last_cnt = 0;
    do_reset();
    push_desc(3'd1, 3'd3);
    for (int s = 0; s < 3; s++) add_sub(256, 3'(s + 1));
    model_txn(3'd1, 3'd3);
    run(4000, 100, 100, 1'b0);
    checks++; if (got_q.size() != 768) begin failures++; $display("FAIL n1t3_count got=%0d exp=768", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i].data[127:32] != 96'd0) upper_nz++;
      if (got_q[i].last) last_cnt++;
      checks++; if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL n1t3_beat %0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++; if (upper_nz != 0) begin failures++; $display("FAIL n1t3_upper_zero got=%0d nonzero beats exp=0", upper_nz); end
    checks++; if (last_cnt != 1 || got_q.size() == 0 || got_q[got_q.size()-1].last !== 1'b1) begin
      failures++; $display("FAIL n1t3_rlast got=%0d rlast beats exp=1 on final beat", last_cnt);
    end
  endtask

  task automatic test_resp_merge();
    sbeat_t b;
    do_reset();
    push_desc(3'd2, 3'd1);
    b.rid = 3'd2; b.data = 32'hAAAA5555; b.resp = 2'd0; b.last = 1'b0; tq.push_back(b);
    b.data = 32'h12345678; b.resp = 2'd2; b.last = 1'b1; tq.push_back(b);
    model_txn(3'd2, 3'd1);
    run(200, 100, 100, 1'b0);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL resp_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() == 1) begin
      checks++; if (got_q[0].resp !== 2'd2 || got_q[0].last !== 1'b1) begin
        failures++; $display("FAIL resp_merge got resp=%0d last=%b exp resp=2 last=1", got_q[0].resp, got_q[0].last);
      end
      checks++; if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL resp_beat got=%h exp=%h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_desc(3'd4, 3'd1);
    add_sub(4, 3'd5);
    model_txn(3'd4, 3'd1);
    run(200, 100, 0, 1'b1);
    checks++; if (m_rvalid !== 1'b1) begin failures++; $display("FAIL pack_latency m_rvalid got=%b exp=1", m_rvalid); end
    for (int i = 0; i < 10; i++) begin
      s_rvalid = 1'b1; s_rdata = $urandom; s_rlast = 1'($urandom_range(0, 1));
      checks++; if (m_rvalid !== 1'b1 || s_rready !== 1'b0 || m_rdata !== exp_q[0].data ||
                    m_rid !== exp_q[0].rid || m_rresp !== exp_q[0].resp || m_rlast !== 1'b1) begin
        failures++; $display("FAIL hold cyc %0d got vld=%b srdy=%b data=%h exp vld=1 srdy=0 data=%h", i, m_rvalid, s_rready, m_rdata, exp_q[0].data);
      end
      @(negedge aclk);
    end
    s_rvalid = 1'b0; m_rready = 1'b1;
    @(negedge aclk);
    m_rready = 1'b0;
    checks++; if (m_rvalid !== 1'b0) begin failures++; $display("FAIL hold_release m_rvalid got=%b exp=0", m_rvalid); end
  endtask

  task automatic test_fifo_full();
    int w = 0;
    logic [2:0] n_raw;
    do_reset();
    push_desc(3'd1, 3'd1);
    while (s_rready !== 1'b1 && w < 10) begin @(negedge aclk); w++; end
    checks++; if (s_rready !== 1'b1) begin failures++; $display("FAIL full_first_load s_rready got=%b exp=1", s_rready); end
    for (int i = 1; i <= 8; i++) begin
      n_raw = (i % 3 == 0) ? 3'd1 : ((i % 3 == 1) ? 3'd2 : 3'd4);
      push_desc(n_raw, 3'(1 + i % 2));
      if (i == 7) begin
        checks++; if (xfer_full_o !== 1'b0) begin failures++; $display("FAIL full_after7 got=%b exp=0", xfer_full_o); end
      end
      if (i == 8) begin
        checks++; if (xfer_full_o !== 1'b1) begin failures++; $display("FAIL full_after8 got=%b exp=1", xfer_full_o); end
      end
    end
    push_desc(3'd2, 3'd2);
    checks++; if (xfer_full_o !== 1'b1) begin failures++; $display("FAIL full_drop got=%b exp=1", xfer_full_o); end
    for (int i = 0; i <= 8; i++) begin
      n_raw = (i % 3 == 0) ? 3'd1 : ((i % 3 == 1) ? 3'd2 : 3'd4);
      for (int s = 0; s < 1 + i % 2; s++) add_sub(3, 3'(i % 8));
      model_txn(n_raw, (i == 0) ? 3'd1 : 3'(1 + i % 2));
    end
    run(3000, 100, 100, 1'b0);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL full_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL full_order beat %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    repeat (5) @(negedge aclk);
    checks++; if (s_rready !== 1'b0 || xfer_full_o !== 1'b0) begin
      failures++; $display("FAIL full_drained got srdy=%b full=%b exp srdy=0 full=0", s_rready, xfer_full_o);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    do_reset();
    for (int i = 0; i < 3; i++) push_desc(3'd4, 3'd1);
    while (s_rready !== 1'b1 && w < 10) begin @(negedge aclk); w++; end
    checks++; if (s_rready !== 1'b1) begin failures++; $display("FAIL mid_collect s_rready got=%b exp=1", s_rready); end
    s_rvalid = 1'b1; s_rid = 3'd5; s_rdata = 32'h11111111; s_rresp = 2'd3; s_rlast = 1'b0;
    @(negedge aclk);
    s_rdata = 32'h22222222;
    @(negedge aclk);
    s_rvalid = 1'b0;
    #2;
    arst_n = 1'b0;
    #1;
    checks++; if (s_rready !== 1'b0 || m_rvalid !== 1'b0 || m_rlast !== 1'b0 || m_rdata !== 128'd0 ||
                  m_rresp !== 2'd0 || m_rid !== 3'd0 || xfer_full_o !== 1'b0) begin
      failures++; $display("FAIL mid_reset got srdy=%b vld=%b last=%b data=%h resp=%0d rid=%0d full=%b exp all 0", s_rready, m_rvalid, m_rlast, m_rdata, m_rresp, m_rid, xfer_full_o);
    end
    @(negedge aclk);
    arst_n = 1'b1;
    repeat (6) @(negedge aclk);
    checks++; if (s_rready !== 1'b0 || m_rvalid !== 1'b0) begin
      failures++; $display("FAIL mid_fifo_empty got srdy=%b vld=%b exp 0 0", s_rready, m_rvalid);
    end
  endtask

  task automatic test_random();
    int nd, t;
    logic [2:0] n_raw, t_raw;
    for (int batch = 0; batch < 12; batch++) begin
      do_reset();
      nd = $urandom_range(1, 4);
      for (int d = 0; d < nd; d++) begin
        n_raw = 3'($urandom_range(0, 7));
        t_raw = 3'($urandom_range(0, 7));
        push_desc(n_raw, t_raw);
        t = (t_raw == 3'd0) ? 1 : int'(t_raw);
        for (int s = 0; s < t; s++) add_sub($urandom_range(1, 6), 3'($urandom_range(0, 7)));
        model_txn(n_raw, t_raw);
      end
      run(4000, $urandom_range(50, 100), $urandom_range(30, 100), 1'b0);
      checks++; if (got_q.size() != exp_q.size()) begin
        failures++; $display("FAIL rand_count batch %0d got=%0d exp=%0d", batch, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand_beat batch %0d beat %0d got=%h exp=%h", batch, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pack4();
    test_n1_t3();
    test_resp_merge();
    test_backpressure();
    test_fifo_full();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
